// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default frame
// geometry used by the baud generator, uart_txd and uart_rxd.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rxd_if.sv
// Receiver-side UART signal bundle: serial line and baud tick in, byte and
// status strobes out. master = receiver, slave = the logic around it.
interface uart_rxd_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
);
  logic                 rs232_rxd;
  logic                 rx_sample_tick;
  logic                 rx_clk_en;
  logic [DATA_BITS-1:0] para_data;
  logic                 rx_done;
  logic                 frame_err;

  modport master (
    input  rs232_rxd, rx_sample_tick,
    output rx_clk_en, para_data, rx_done, frame_err
  );

  modport slave (
    output rs232_rxd, rx_sample_tick,
    input  rx_clk_en, para_data, rx_done, frame_err
  );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input; both flops reset
// to RST_VAL so the output is quiet while reset is held.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rxd.sv
// 8N1 UART receiver: start-bit detect, mid-bit sampling off an oversampling
// tick, LSB-first shift, stop-bit check with rx_done / frame_err strobes.
module uart_rxd
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic      uart_clk,
  input  logic      uart_rst_n,
  uart_rxd_if.master bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] MID_T  = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] LAST_T = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_B = BW'(DATA_BITS - 1);

  logic rxd_s;
  logic tick;

  rx_state_e            state_q, state_d;
  logic [TW-1:0]        cnt_q,   cnt_d;
  logic [BW-1:0]        idx_q,   idx_d;
  logic [DATA_BITS-1:0] sh_q,    sh_d;
  logic [DATA_BITS-1:0] data_q,  data_d;
  logic                 done_q,  done_d;
  logic                 ferr_q,  ferr_d;
  logic                 en_q,    en_d;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (uart_clk),
    .rst_n (uart_rst_n),
    .d     (bus.rs232_rxd),
    .q     (rxd_s)
  );

  assign tick = bus.rx_sample_tick;

  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      en_q    <= en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rxd_s) state_d = START;
      end
      START: if (tick) begin
        // Mid start bit: a line back high means a glitch, not a frame.
        if (cnt_q == MID_T) begin
          cnt_d   = '0;
          state_d = rxd_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: if (tick) begin
        if (cnt_q == LAST_T) begin
          cnt_d = '0;
          sh_d  = {rxd_s, sh_q[DATA_BITS-1:1]};
          if (idx_q == LAST_B) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: if (tick) begin
        // Decided at mid stop bit so a back-to-back start edge is not missed.
        if (cnt_q == LAST_T) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rxd_s) begin
            data_d = sh_q;
            done_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    en_d = (state_d != IDLE);
  end

  assign bus.rx_clk_en = en_q;
  assign bus.para_data = data_q;
  assign bus.rx_done   = done_q;
  assign bus.frame_err = ferr_q;
endmodule

// File: tb/tb_uart_rxd.sv
// Directed bench for uart_rxd: table of frames plus hand sequences for
// glitch rejection and mid-frame reset.
module tb_uart_rxd;
  localparam int OS  = 16;
  localparam int LAT = OS/2 + 9*OS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rxd_if #(.DATA_BITS(8)) bus();

  uart_rxd #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .uart_clk   (clk),
    .uart_rst_n (rst_n),
    .bus        (bus)
  );

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         gap;
    bit         irr;
    int         exp_done;
    int         exp_err;
    logic [7:0] exp_para;
  } vec_t;

  int pass_cnt = 0, total_cnt = 0;
  bit irr = 1'b0;
  int done_cnt = 0, err_cnt = 0, lat = 0, last_lat = 0, dual_cnt = 0;

  // Tick generator: every 2 clocks, or a random 3..7 clocks when irr is set.
  initial begin
    bus.rx_sample_tick = 1'b0;
    forever begin : tg
      int n;
      n = irr ? int'($urandom_range(7, 3)) : 2;
      @(posedge clk); #1 bus.rx_sample_tick = 1'b1;
      repeat (n - 1) begin
        @(posedge clk); #1 bus.rx_sample_tick = 1'b0;
      end
    end
  end

  // Strobe monitor: counts strobes and the ticks consumed while enabled.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.rx_done || bus.frame_err) begin
        if (bus.rx_done && bus.frame_err) dual_cnt++;
        if (bus.rx_done)   done_cnt++;
        if (bus.frame_err) err_cnt++;
        last_lat = lat;
      end
      if (!bus.rx_clk_en) lat = 0;
      else if (bus.rx_sample_tick) lat++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (bus.rx_sample_tick !== 1'b1);
    end
  endtask

  task automatic line(input logic b, input int n);
    #2 bus.rs232_rxd = b;
    wait_ticks(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok);
    line(1'b0, OS);
    for (int i = 0; i < 8; i++) line(d[i], OS);
    if (stop_ok) line(1'b1, OS);
    else         line(1'b0, 12);
  endtask

  vec_t vecs[6];
  int d0, e0;

  initial begin
    vecs[0] = '{8'h55, 1'b1, 10, 1'b0, 1, 0, 8'h55};
    vecs[1] = '{8'hA5, 1'b1,  4, 1'b0, 1, 0, 8'hA5};
    vecs[2] = '{8'h3C, 1'b1,  0, 1'b0, 1, 0, 8'h3C};
    vecs[3] = '{8'hF0, 1'b0, 10, 1'b0, 0, 1, 8'h3C};
    vecs[4] = '{8'h00, 1'b1, 10, 1'b1, 1, 0, 8'h00};
    vecs[5] = '{8'hFF, 1'b1,  0, 1'b1, 1, 0, 8'hFF};

    bus.rs232_rxd = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_clk_en", 32'(bus.rx_clk_en), 0);
    check("rst_para",   32'(bus.para_data), 0);
    check("rst_done",   32'(bus.rx_done),   0);
    check("rst_ferr",   32'(bus.frame_err), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    line(1'b1, 10);

    for (int v = 0; v < 6; v++) begin
      irr = vecs[v].irr;
      d0 = done_cnt; e0 = err_cnt;
      if (vecs[v].gap > 0) line(1'b1, vecs[v].gap);
      send_frame(vecs[v].data, vecs[v].stop_ok);
      @(negedge clk);
      check($sformatf("v%0d_done", v), 32'(done_cnt - d0), 32'(vecs[v].exp_done));
      check($sformatf("v%0d_ferr", v), 32'(err_cnt - e0),  32'(vecs[v].exp_err));
      check($sformatf("v%0d_para", v), 32'(bus.para_data), 32'(vecs[v].exp_para));
      check($sformatf("v%0d_lat",  v), 32'(last_lat),      32'(LAT));
    end

    // Short low glitch: enable must rise then fall with no strobe.
    irr = 1'b0;
    line(1'b1, 20);
    d0 = done_cnt; e0 = err_cnt;
    @(posedge clk); #2 bus.rs232_rxd = 1'b0;
    repeat (3) @(negedge clk);
    check("glitch_en_before", 32'(bus.rx_clk_en), 0);
    @(negedge clk);
    check("glitch_en_rise", 32'(bus.rx_clk_en), 1);
    wait_ticks(2);
    line(1'b1, 20);
    @(negedge clk);
    check("glitch_en_drop", 32'(bus.rx_clk_en), 0);
    check("glitch_done", 32'(done_cnt - d0), 0);
    check("glitch_ferr", 32'(err_cnt - e0), 0);

    // Reset in the middle of bit 4 of 0x81, then a clean 0x81.
    d0 = done_cnt;
    line(1'b0, OS);
    line(1'b1, OS);
    for (int i = 1; i < 4; i++) line(1'b0, OS);
    line(1'b0, 8);
    check("mid_en_high", 32'(bus.rx_clk_en), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_en",   32'(bus.rx_clk_en), 0);
    check("mid_rst_para", 32'(bus.para_data), 0);
    check("mid_rst_done", 32'(bus.rx_done),   0);
    check("mid_rst_ferr", 32'(bus.frame_err), 0);
    bus.rs232_rxd = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    line(1'b1, 10);
    check("mid_rst_nostrobe", 32'(done_cnt - d0), 0);
    send_frame(8'h81, 1'b1);
    @(negedge clk);
    check("post_rst_para", 32'(bus.para_data), 32'h81);
    check("post_rst_done", 32'(done_cnt - d0), 1);
    check("post_rst_lat",  32'(last_lat), 32'(LAT));

    check("no_dual_strobe", 32'(dual_cnt), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
